store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Store-side data path between the pipeline's memory stage and a word-only data memory with no byte enables. It narrows a 32-bit register value to a byte or halfword lane and performs read-modify-write for `sb`/`sh`; `sw` is written directly. Misaligned or illegal requests are rejected with an error pulse and never touch memory. Load-side extension is handled elsewhere in the memory stage, not in this block.

## Interface
Parameters:
- `MEM_AW`, default 30: word-address width driven to memory, taken from byte address bits [MEM_AW+1:2].

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: store request present.
- `req_ready` out 1: block idle and accepting requests.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: register value (rt); only the low byte/half is used for `sb`/`sh`.
- `req_type` in 2: 00 `sw`, 01 `sh`, 10 `sb`, 11 illegal.
- `done` out 1: one-cycle pulse, store committed.
- `align_err` out 1: one-cycle pulse, request rejected.
- `mem_addr` out MEM_AW: word address.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en` out 1: memory write strobe.
- `mem_wdata` out 32: full word to write.

## Operation
- Accept on `req_valid && req_ready`; latch addr, wdata, and type.
- Alignment check at accept: `sw` requires addr[1:0]=00; `sh` requires addr[0]=0; `sb` is always aligned; type 11 is always illegal. On failure, register `align_err` for the next cycle, stay IDLE, and issue no memory strobes.
- FSM states: IDLE, RD, WAIT, WR.
  - IDLE: accepted `sw` goes to WR; accepted `sh`/`sb` goes to RD; rejected requests stay in IDLE.
  - RD: `mem_rd_en`=1; go to WAIT.
  - WAIT: capture `mem_rdata` into the merge register; go to WR.
  - WR: `mem_wr_en`=1, `done`=1; go to IDLE.
- Merge (little-endian), with `old` = captured word:
  - `sb`: byte lane k=addr[1:0] gets wdata[7:0] at bits [8k+7:8k]; other bytes come from `old`.
  - `sh`: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], using wdata[15:0]; the rest comes from `old`.
  - `sw`: `mem_wdata` = wdata unchanged.
- `mem_addr` = latched addr[MEM_AW+1:2], held constant through RD, WAIT, and WR. It is 0 in IDLE.
- `req_ready` = (state == IDLE).
- `done`, `mem_rd_en`, and `mem_wr_en` are decoded from state. `align_err` is registered.

## Timing
- Reset (async, any state): state goes to IDLE. `req_ready`=1; `done`, `align_err`, `mem_rd_en`, `mem_wr_en`=0; `mem_addr`, `mem_wdata`=0.
- Reset mid-operation (RD/WAIT/WR) aborts the store with no write, including a WR cycle cut by reset before the clock edge.
- `sw`: accepted in cycle 0, WR/`done` in cycle 1, `req_ready` in cycle 2. One memory access.
- `sh`/`sb`: accepted in cycle 0, RD in 1, WAIT in 2, WR/`done` in 3, `req_ready` in 4. Exactly one read and one write.
- Rejected request: accepted in cycle 0, `align_err` in cycle 1. `req_ready` stays 1, so a new request may be accepted in cycle 1.
- `req_valid` is ignored while `req_ready`=0. There is no queuing; the upstream stage holds the request until accepted.
- `done` and `align_err` are never both high.
- Memory read latency is exactly one cycle. No other latency is supported.

## Structure
- Shared package holds:
  - store-type codes `ST_SW`=2'b00, `ST_SH`=2'b01, `ST_SB`=2'b10;
  - FSM state enum (IDLE, RD, WAIT, WR);
  - lane-width constants (8, 16).
- One combinational sub-module, `store_lane_merge`. Inputs: old word, wdata, type, addr[1:0]. Output: merged word. The FSM instantiates it once.

## Test plan
- `sw` addr 0x0000_0010, wdata 0xDEAD_BEEF → cycle 1: `mem_wr_en`=1, `mem_addr`=4, `mem_wdata`=0xDEAD_BEEF, `done`=1; no `mem_rd_en`.
- `sb` addr 0x0000_0013, wdata 0x0000_00AA, memory word = 0x1122_3344 → RD in cycle 1, WR in cycle 3 with `mem_wdata`=0xAA22_3344; `done` in cycle 3.
- `sh` addr 0x0000_0006, wdata 0x0000_BEEF, memory word = 0x1122_3344 → `mem_wdata`=0xBEEF_3344; `sh` at 0x4 gives 0x1122_BEEF.
- Misalignment: `sw` at 0x2, `sh` at 0x1, and type 11 each give `align_err` the next cycle, with zero memory strobes; a valid `sb` presented in that same cycle is accepted.
- `rst_n` low during WAIT of an `sb` → outputs go to reset values immediately; no `mem_wr_en` ever; `req_ready`=1 after release.
- `req_valid` held high for back-to-back `sb`,`sw`,`sh` → strobes follow the latencies above and `req_ready` is low throughout each operation.

Source files
------------

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store narrowing data path: store-type codes,
// FSM states, lane widths and the alignment rule applied at accept time.
package store_narrow_unit_pkg;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    WR   = 2'd3
  } state_t;

  // A request that fails this check is rejected without touching memory.
  function automatic logic is_aligned(input logic [1:0] st_type,
                                      input logic [1:0] addr_lo);
    case (st_type)
      ST_SW:   return addr_lo == 2'b00;
      ST_SH:   return !addr_lo[0];
      ST_SB:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: drops the new byte/halfword into the word read
// back from memory; a full-word store passes the register value through.
module store_lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    merged = old_word;
    case (st_type)
      ST_SB:   merged[{addr_lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      ST_SH:   merged[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store-side data path to a word-only memory: sw writes directly, sb/sh do
// read-modify-write, misaligned or illegal requests pulse align_err.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_type,
  output logic              done,
  output logic              align_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, old_q, merged;
  logic [1:0]  type_q;
  logic        align_err_q;
  logic        accept, legal;

  assign accept = req_valid && req_ready;
  assign legal  = is_aligned(req_type, req_addr[1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      align_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      type_q      <= ST_SW;
      old_q       <= '0;
    end else begin
      state_q     <= state_d;
      align_err_q <= accept && !legal;
      if (accept && legal) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        type_q  <= req_type;
      end
      // Read data arrives exactly one cycle after the RD strobe.
      if (state_q == WAIT) old_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && legal) state_d = (req_type == ST_SW) ? WR : RD;
      RD:   state_d = WAIT;
      WAIT: state_d = WR;
      WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  store_lane_merge u_merge (
    .old_word (old_q),
    .wdata    (wdata_q),
    .st_type  (type_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged)
  );

  assign req_ready = (state_q == IDLE);
  assign mem_rd_en = (state_q == RD);
  assign mem_wr_en = (state_q == WR);
  assign done      = (state_q == WR);
  assign align_err = align_err_q;
  assign mem_addr  = (state_q == IDLE) ? '0 : addr_q[MEM_AW+1:2];
  assign mem_wdata = (state_q == WR) ? merged : '0;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: word-memory model, expected writes
// queued at issue and popped when the write strobe appears.
module tb_store_narrow_unit;
  import store_narrow_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_type;
  logic        done, align_err;
  logic [29:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata, mem_wdata;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  store_narrow_unit #(.MEM_AW(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_type  (req_type),
    .done      (done),
    .align_err (align_err),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  // Word memory, one-cycle read latency, plus a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
    if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    step();
    pl_en = 1'b0;
  endtask

  // Legal store: check the whole latency profile and pop the scoreboard on the write.
  task automatic issue(input string name, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_word, input bit keep);
    wr_t e;
    check({name, "_ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = d;
    e.addr = a[31:2]; e.data = exp_word;
    sb_q.push_back(e);
    step();
    if (!keep) req_valid = 1'b0;
    if (t != ST_SW) begin
      check({name, "_rd_en"}, mem_rd_en, 1);
      check({name, "_rd_addr"}, mem_addr, a[31:2]);
      check({name, "_rd_busy"}, {req_ready, mem_wr_en, done, align_err}, 0);
      step();
      check({name, "_wait_quiet"}, {req_ready, mem_rd_en, mem_wr_en, done}, 0);
      step();
    end
    check({name, "_wr_strobes"}, {mem_wr_en, done, mem_rd_en, align_err, req_ready}, 5'b11000);
    if (mem_wr_en && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, "_wr_addr"}, mem_addr, e.addr);
      check({name, "_wr_data"}, mem_wdata, e.data);
    end else begin
      checks++;
      errors++;
      $error("FAIL %s_sb_pop observed=no_write expected=write", name);
    end
    step();
    check({name, "_ready_out"}, {req_ready, done, mem_wr_en}, 3'b100);
  endtask

  // Rejected request: align_err next cycle, still ready, no strobes. Leaves req_valid high.
  task automatic reject(input string name, input logic [1:0] t, input logic [31:0] a);
    check({name, "_ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = 32'hFFFF_FFFF;
    step();
    check({name, "_err"}, {align_err, done, req_ready, mem_rd_en, mem_wr_en}, 5'b10100);
  endtask

  initial begin
    int rc, wc;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_type = ST_SW;
    #1;
    check("reset_outs", {req_ready, done, align_err, mem_rd_en, mem_wr_en}, 5'b10000);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    step(); step();
    rst_n = 1'b1;
    preload(4'd4, 32'h1122_3344);
    preload(4'd1, 32'h1122_3344);
    check("idle_addr", mem_addr, 0);

    issue("sb13", ST_SB, 32'h0000_0013, 32'h0000_00AA, 32'hAA22_3344, 1'b0);
    issue("sw10", ST_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    issue("sh06", ST_SH, 32'h0000_0006, 32'h0000_BEEF, 32'hBEEF_3344, 1'b0);
    preload(4'd1, 32'h1122_3344);
    issue("sh04", ST_SH, 32'h0000_0004, 32'h1234_BEEF, 32'h1122_BEEF, 1'b0);
    check("mem4_sw", mem[4], 32'hDEAD_BEEF);
    check("mem1_sh", mem[1], 32'h1122_BEEF);

    rc = rd_cnt; wc = wr_cnt;
    reject("rej_sw2", ST_SW, 32'h0000_0002);
    reject("rej_sh1", ST_SH, 32'h0000_0001);
    reject("rej_ill", ST_ILL, 32'h0000_0000);
    req_valid = 1'b0;
    step();
    check("rej_clear", {align_err, req_ready}, 2'b01);
    step();
    check("rej_no_rd", rd_cnt, rc);
    check("rej_no_wr", wr_cnt, wc);

    preload(4'd2, 32'hFFFF_FFFF);
    reject("rej_sw1", ST_SW, 32'h0000_0009);
    issue("sb08", ST_SB, 32'h0000_0008, 32'h0000_005A, 32'hFFFF_FF5A, 1'b0);
    check("mem2_sb", mem[2], 32'hFFFF_FF5A);

    preload(4'd8, 32'h5566_7788);
    preload(4'd10, 32'h0102_0304);
    issue("b2b_sb", ST_SB, 32'h0000_0021, 32'h1234_5699, 32'h5566_9988, 1'b1);
    issue("b2b_sw", ST_SW, 32'h0000_0024, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    issue("b2b_sh", ST_SH, 32'h0000_002A, 32'hABCD_7777, 32'h7777_0304, 1'b0);
    check("mem8", mem[8], 32'h5566_9988);
    check("mem9", mem[9], 32'hCAFE_F00D);
    check("mem10", mem[10], 32'h7777_0304);

    // Reset during WAIT of an sb aborts the store.
    preload(4'd12, 32'h0123_4567);
    wc = wr_cnt;
    req_valid = 1'b1; req_type = ST_SB; req_addr = 32'h0000_0031; req_wdata = 32'h0000_00EE;
    step();
    req_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_outs", {req_ready, done, align_err, mem_rd_en, mem_wr_en}, 5'b10000);
    check("rst_wait_addr", mem_addr, 0);
    check("rst_wait_wdata", mem_wdata, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_wait_ready", req_ready, 1);
    check("rst_wait_no_wr", wr_cnt, wc);
    check("rst_wait_mem", mem[12], 32'h0123_4567);

    // Reset landing inside the WR cycle of an sw also suppresses the write.
    preload(4'd13, 32'h0BAD_F00D);
    wc = wr_cnt;
    req_valid = 1'b1; req_type = ST_SW; req_addr = 32'h0000_0034; req_wdata = 32'h1111_2222;
    step();
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_outs", {req_ready, done, mem_wr_en}, 3'b100);
    step();
    rst_n = 1'b1;
    step();
    check("rst_wr_no_wr", wr_cnt, wc);
    check("rst_wr_mem", mem[13], 32'h0BAD_F00D);

    check("sb_queue_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
